// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   Each conversion step shifts the {bcd, bin} register right by one, then
//   subtracts 3 from every BCD digit field that is >= 8. After BIN_W steps
//   the bin field holds the binary value of the original BCD word.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   start    conversion request, sampled only while idle
//   bcd_in   packed BCD operand (digit 0 in bits [3:0]), sampled with start
//   busy     high while a conversion is running
//   done     one-cycle pulse, bin_out/err valid in that cycle
//   err      raised with done when any input digit is > 9
//   bin_out  binary result, holds until the next conversion completes
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// block is idle (busy=0). Requests while busy=1 are dropped, not queued.
// Every accepted request produces exactly one done pulse: one cycle after
// the accept edge for an invalid operand, BIN_W+1 cycles after it for a
// valid one. done and busy are never high together, and start may be held
// or reasserted in the done cycle to begin the next conversion at once.

module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int REG_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state;
  logic [REG_W-1:0]   sh;
  logic [REG_W-1:0]   sh_next;
  logic [CNT_W-1:0]   cnt;
  logic               bad_digit;

  // Any digit above 9 makes the operand unconvertible.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step. A valid digit shifted right is at most
  // 12 (a 1 entering from the digit above adds 8), so the subtract-3 on
  // digits >= 8 never underflows.
  always_comb begin
    sh_next = sh >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sh_next[BIN_W + 4*d +: 4] >= 4'd8) begin
        sh_next[BIN_W + 4*d +: 4] = sh_next[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (bad_digit) begin
              // Reject immediately: report through the normal done pulse.
              done    <= 1'b1;
              err     <= 1'b1;
              bin_out <= '0;
            end else begin
              sh    <= {bcd_in, {BIN_W{1'b0}}};
              cnt   <= '0;
              busy  <= 1'b1;
              err   <= 1'b0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          sh  <= sh_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            bin_out <= sh_next[BIN_W-1:0];
            done    <= 1'b1;
            err     <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int BCD_W  = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BCD_W-1:0]  bcd_in = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  bin_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: decimal value of the digit string, or error flag.
  function automatic logic [BIN_W:0] model(input logic [BCD_W-1:0] b);
    int v;
    bit e;
    int dig;
    v = 0;
    e = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = int'((b >> (4 * d)) & 'hF);
      if (dig > 9) e = 1'b1;
      v = v * 10 + dig;
    end
    if (e) return {1'b1, {BIN_W{1'b0}}};
    return {1'b0, BIN_W'(v)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [BIN_W:0] exp_q[$];    // {err, bin}
  int             exp_cyc_q[$]; // cycle number in which done must be seen
  int             busy_cnt = 0;

  task automatic push_exp(input logic [BCD_W-1:0] b, input int accept_cyc);
    logic [BIN_W:0] m;
    m = model(b);
    exp_q.push_back(m);
    exp_cyc_q.push_back(m[BIN_W] ? accept_cyc : accept_cyc + BIN_W);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [BIN_W:0] e;
    int             ec;
    if (rst) begin
      busy_cnt = 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("done_with_busy", int'(busy), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("bin_out", int'(bin_out), int'(e[BIN_W-1:0]));
          check("err", int'(err), int'(e[BIN_W]));
          check("done_cycle", cyc, ec);
          check("busy_cycles", busy_cnt, e[BIN_W] ? 0 : BIN_W);
        end
        busy_cnt = 0;
      end else if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
        check("missing_done", cyc, exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request from idle and return in the cycle its done is due.
  task automatic do_conv(input logic [BCD_W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    push_exp(b, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    if (!model(b)[BIN_W]) repeat (BIN_W) @(negedge clk);
  endtask

  task automatic finish_run();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BCD_W-1:0] b;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_bin", int'(bin_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 99, then check done falls and bin_out holds
    do_conv(8'h99);
    @(negedge clk);
    check("done_falls", int'(done), 0);
    check("bin_holds", int'(bin_out), 99);

    // Sweep all valid codes
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        b = BCD_W'((t << 4) | u);
        do_conv(b);
      end
    end

    // Invalid digits, then a valid follow-up
    do_conv(8'h1A);
    do_conv(8'hA0);
    do_conv(8'h25);

    // Random codes, valid and invalid
    for (int i = 0; i < 40; i++) begin
      b = BCD_W'($urandom_range(0, 255));
      do_conv(b);
    end

    // Start while busy is ignored; bcd_in changes during CONV are ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h37;
    push_exp(8'h37, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      bcd_in = BCD_W'($urandom_range(0, 255));
      @(negedge clk);
    end
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h64;
    push_exp(8'h64, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_bin", int'(bin_out), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    do_conv(8'h12);

    // Back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 8'h50;
    push_exp(8'h50, cyc + 1);
    repeat (BIN_W + 1) @(negedge clk);
    check("b2b_done1", int'(done), 1);
    bcd_in = 8'h08;
    push_exp(8'h08, cyc + 1);
    @(negedge clk);
    check("b2b_busy_rise", int'(busy), 1);
    check("b2b_done_fall", int'(done), 0);
    start = 1'b0;
    repeat (BIN_W + 2) @(negedge clk);

    finish_run();
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL timeout: got cycle %0d want completion", cyc);
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each BCD digit that is ≥8.
- Decodes packed BCD words, such as the 8-bit {carry, digit} results of the BCD adder path, back into plain binary for downstream arithmetic and compare logic.
- One conversion in flight at a time.
- Start/busy/done handshake; invalid-digit detection.

Parameters:
- DIGITS, 2, number of packed BCD digits at the input (4 bits each, digit 0 in bits [3:0]).
- BIN_W, 7, binary result width; must satisfy 10^DIGITS-1 < 2^BIN_W. Also the number of shift iterations.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD operand; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is running.
- done  output  1  one-cycle pulse; bin_out/err valid in that cycle.
- err  output  1  set with done when any input digit > 9.
- bin_out  output  BIN_W  binary result; holds until the next accepted start.

Behaviour:
- Reset (asynchronous, any time including mid-conversion):
  - State IDLE; busy=0, done=0, err=0, bin_out=0.
  - Shift register and counter cleared.
  - Any in-flight conversion is abandoned, with no done pulse.
- States: IDLE, CONV.
- IDLE, start=1 at edge E0, all digits ≤9:
  - Load shift register {bcd_in, BIN_W'b0}.
  - Iteration counter=0; go to CONV; busy=1 after E0; done=0; err=0.
- IDLE, start=1 at E0, any digit >9:
  - No conversion; stay IDLE.
  - After E0: done=1, err=1, bin_out=0, busy=0.
- IDLE, start=0: done deasserts on the next edge; err and bin_out hold.
- Each CONV edge:
  - Logical right shift of the whole {bcd, bin} register by 1; the bcd LSB enters the bin MSB.
  - Then, on the shifted value, each 4-bit digit field ≥8 has 3 subtracted (all digits in parallel, same edge).
  - Counter increments.
- On edge E0+BIN_W (the BIN_W-th shift edge):
  - bin_out ← final bin field; done=1, err=0, busy=0; state IDLE.
- Latency: done high in the cycle after E0+BIN_W. Default params give 7 edges, with done visible in cycle 8.
- Throughput: start held high or reasserted during the done cycle is accepted on that edge (state is IDLE). done drops and busy rises on the same edge, so back-to-back conversions start every BIN_W+1 cycles.
- start while busy=1: ignored, with no queuing; bcd_in changes during CONV do not affect the result.
- done is never high together with busy.
- Arithmetic: digit correction is a 4-bit subtract. Since a shifted digit is ≤12 after a right shift of a valid digit, no underflow is possible. Internal register width is 4*DIGITS+BIN_W.
- Counter width: clog2(BIN_W+1).

Test Plan:
- Reset, then start with bcd_in=8'h99 at E0 -> busy=1 for 7 cycles; done=1 in cycle 8 with bin_out=7'd99, err=0; done low the next cycle, bin_out holds 99.
- Sweep bcd_in over 8'h00..8'h99 (valid codes only) -> bin_out = 10*tens+units for each (00→0, 10→10, 42→42, 80→80), err=0, each latency exactly 7.
- bcd_in=8'h1A, then 8'hA0 -> done and err high in the cycle after the start edge, bin_out=0, busy never high; a following start with 8'h25 gives bin_out=25, err=0.
- Start 8'h37, then pulse start with bcd_in=8'h55 at cycle 3, and change bcd_in repeatedly during CONV -> result 37; no second done; busy continuous.
- Start 8'h64, assert rst asynchronously mid-cycle at iteration 4 -> outputs 0 immediately; no done after release; a new start with 8'h12 gives 12.
- start held high with 8'h50 then 8'h08 (changed in the done cycle) -> done pulses every 8 cycles with bin_out 50 then 8; busy rises on the same edge done falls.
